uart_tx_axis: RTL

//  - Standalone UART transmitter with an AXI-stream slave input. It serialises bytes from the USB CDC
//    OUT path (out_data/out_valid/out_ready) onto txd, and is the send-side counterpart of the UART receive path.
//  - Runs in the 48 MHz PLL domain. Its bit timing uses the same 1/8-bit prescale convention as the

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_tx_axis.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive paths.
package uart_pkg;

  localparam int PRESCALE_W = 16;
  localparam int BIT_TMR_W  = 19;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // A prescale of zero would give a zero-length bit, so it is clamped to one.
  function automatic logic [BIT_TMR_W-1:0] bit_period(input logic [PRESCALE_W-1:0] prescale);
    logic [PRESCALE_W-1:0] eff;
    eff = (prescale == '0) ? PRESCALE_W'(1) : prescale;
    return {eff, 3'b000};
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loads a period, then emits a one-cycle tick at the end of every period.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 load_i,
  input  logic                 en_i,
  input  logic [BIT_TMR_W-1:0] period_i,
  output logic                 tick_o
);

  logic [BIT_TMR_W-1:0] reload_q;
  logic [BIT_TMR_W-1:0] cnt_q;

  // The period is captured on load so later changes to period_i do not disturb a running frame.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      reload_q <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      reload_q <= period_i - BIT_TMR_W'(1);
      cnt_q    <= period_i - BIT_TMR_W'(1);
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_q <= reload_q;
      end else begin
        cnt_q <= cnt_q - BIT_TMR_W'(1);
      end
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_axis.sv
// UART transmitter fed by an AXI-stream slave; frames bytes onto txd_o with optional parity.
module uart_tx_axis
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  txd_o,
  output logic                  busy_o
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic stop_cnt_q, stop_cnt_d;
  logic parity_q, parity_d;
  logic txd_d, tready_d, busy_d;
  logic handshake, tick, timer_en, stop_last;
  logic [BIT_TMR_W-1:0] period;

  assign handshake = s_axis_tvalid && s_axis_tready;
  assign period    = bit_period(prescale_i);
  assign timer_en  = (state_q != IDLE);
  assign stop_last = (STOP_BITS == 1) || stop_cnt_q;

  uart_bit_timer u_bit_timer (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .load_i   (handshake),
    .en_i     (timer_en),
    .period_i (period),
    .tick_o   (tick)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      idx_q         <= '0;
      stop_cnt_q    <= 1'b0;
      parity_q      <= 1'b0;
      txd_o         <= 1'b1;
      s_axis_tready <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      idx_q         <= idx_d;
      stop_cnt_q    <= stop_cnt_d;
      parity_q      <= parity_d;
      txd_o         <= txd_d;
      s_axis_tready <= tready_d;
      busy_o        <= busy_d;
    end
  end

  // Every output is the registered copy of its next value, so txd_o changes only on clock edges.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    txd_d      = txd_o;
    tready_d   = s_axis_tready;
    busy_d     = busy_o;

    case (state_q)
      IDLE: begin
        txd_d    = 1'b1;
        tready_d = 1'b1;
        busy_d   = 1'b0;
        if (handshake) begin
          state_d    = START;
          shift_d    = s_axis_tdata;
          idx_d      = '0;
          stop_cnt_d = 1'b0;
          parity_d   = (PARITY == PAR_ODD) ? ~^s_axis_tdata : ^s_axis_tdata;
          txd_d      = 1'b0;
          tready_d   = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            if (PARITY != PAR_NONE) begin
              state_d = uart_pkg::PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        // Leaving STOP re-opens tready, so a held tvalid handshakes on the very next edge.
        if (tick) begin
          if (stop_last) begin
            state_d  = IDLE;
            tready_d = 1'b1;
            busy_d   = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule
